// File: rtl/spi_register_controller.sv
// Sequencer from a chip-select framed SPI byte stream to register-file writes and readback.
// SPI-side inputs are resynchronised here; register updates are held off via _HOLD until frame end.
`timescale 1ns/1ps
module spi_register_controller #(
    parameter int unsigned NumOfRegisters = 4,
    parameter int unsigned SyncStages     = 2  // must be >= 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       _CS,
    input  logic       RXDone,
    input  logic [7:0] RXData,
    input  logic [7:0] ReadData,
    output logic [7:0] AddressBus,
    output logic [7:0] WriteBus,
    output logic       _Write,
    output logic       _HOLD,
    output logic [7:0] TXData,
    output logic       Busy,
    output logic       ErrorFlag
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCmd   = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StRead  = 2'd3;

    logic [SyncStages-1:0] cs_sync;
    logic [SyncStages-1:0] rx_sync;
    logic                  cs_s;
    logic                  rx_s;
    logic                  cs_prev;
    logic                  rx_prev;
    logic                  byte_ev;
    logic                  cs_fall;
    logic [1:0]            state;
    logic [6:0]            addr;
    logic                  inc1;
    logic                  inc2;
    logic                  write_now;

    function automatic logic in_range(input logic [6:0] a);
        return 32'(a) < NumOfRegisters;
    endfunction

    // Wraps at the top register; out-of-range addresses wrap naturally at 127 -> 0.
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (32'(a) == NumOfRegisters - 1) begin
            return 7'd0;
        end
        return a + 7'd1;
    endfunction

    assign cs_s       = cs_sync[SyncStages-1];
    assign rx_s       = rx_sync[SyncStages-1];
    assign byte_ev    = rx_s & ~rx_prev;
    // cs_prev resets low so a frame already in progress at reset is not mistaken for a new one.
    assign cs_fall    = cs_prev & ~cs_s;
    assign write_now  = (state == StWrite) && byte_ev && in_range(addr);
    assign AddressBus = {1'b0, addr};
    assign Busy       = (state != StIdle);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_sync   <= '0;
            rx_sync   <= '0;
            cs_prev   <= 1'b0;
            rx_prev   <= 1'b0;
            state     <= StIdle;
            addr      <= 7'd0;
            WriteBus  <= 8'h00;
            _Write    <= 1'b1;
            _HOLD     <= 1'b1;
            TXData    <= 8'h00;
            ErrorFlag <= 1'b0;
            inc1      <= 1'b0;
            inc2      <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[SyncStages-2:0], _CS};
            rx_sync <= {rx_sync[SyncStages-2:0], RXDone};
            cs_prev <= cs_s;
            rx_prev <= rx_s;
            _Write  <= 1'b1;
            inc1    <= 1'b0;
            inc2    <= inc1;
            // Post-write increment lands the cycle after the strobe ends, even if the frame closed.
            if (inc2) begin
                addr <= next_addr(addr);
            end

            case (state)
                StIdle: begin
                    if (cs_fall) begin
                        state     <= StCmd;
                        ErrorFlag <= 1'b0;
                        _HOLD     <= 1'b0;
                    end else if (!_HOLD && _Write) begin
                        _HOLD <= 1'b1;
                    end
                end
                StCmd: begin
                    if (byte_ev) begin
                        addr  <= RXData[6:0];
                        state <= RXData[7] ? StRead : StWrite;
                        if (!in_range(RXData[6:0])) begin
                            ErrorFlag <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (byte_ev) begin
                        inc1 <= 1'b1;
                        if (in_range(addr)) begin
                            WriteBus <= RXData;
                            _Write   <= 1'b0;
                        end else begin
                            ErrorFlag <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    TXData <= in_range(addr) ? ReadData : 8'h00;
                    if (byte_ev) begin
                        addr <= next_addr(addr);
                    end
                end
                default: state <= StIdle;
            endcase

            // A strobe issued on the closing edge keeps _HOLD low until the strobe has ended.
            if (state != StIdle && cs_s) begin
                state <= StIdle;
                if (!write_now) begin
                    _HOLD <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_register_controller.sv
// Randomised frame-level bench for spi_register_controller against a byte-stream reference model.
`timescale 1ns/1ps
module tb_spi_register_controller;

    localparam int unsigned NumRegs = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cs_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] read_data;
    logic [7:0] address_bus;
    logic [7:0] write_bus;
    logic       write_n;
    logic       hold_n;
    logic [7:0] tx_data;
    logic       busy;
    logic       error_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    bit         busy_seen;

    always #5 CLK = ~CLK;

    assign read_data = 8'h10 + address_bus;

    spi_register_controller #(
        .NumOfRegisters(NumRegs),
        .SyncStages    (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        ._CS       (cs_n),
        .RXDone    (rx_done),
        .RXData    (rx_data),
        .ReadData  (read_data),
        .AddressBus(address_bus),
        .WriteBus  (write_bus),
        ._Write    (write_n),
        ._HOLD     (hold_n),
        .TXData    (tx_data),
        .Busy      (busy),
        .ErrorFlag (error_flag)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every low cycle of _Write is logged, so a stretched strobe shows up as an extra write.
    always @(negedge CLK) begin
        if (busy) busy_seen = 1'b1;
        if (!write_n) begin
            wr_addr_q.push_back(address_bus);
            wr_data_q.push_back(write_bus);
            check_eq("hold_low_during_write", 32'(hold_n), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit end_frame);
        rx_data = b;
        rx_done = 1'b1;
        if (end_frame) cs_n = 1'b1;
        tick(4);
        rx_done = 1'b0;
        tick(6);
    endtask

    function automatic logic [6:0] model_inc(input logic [6:0] a);
        return (int'(a) == NumRegs - 1) ? 7'd0 : 7'((int'(a) + 1) % 128);
    endfunction

    function automatic logic [7:0] model_tx(input logic [6:0] a);
        return (int'(a) < NumRegs) ? 8'(8'h10 + int'(a)) : 8'h00;
    endfunction

    task automatic run_frame(input logic [7:0] bytes[$], input bit coincident);
        logic [7:0] exp_a[$];
        logic [7:0] exp_d[$];
        logic [6:0] a;
        logic [7:0] cmd;
        bit         err;
        bit         rd;
        bit         last;
        a   = 7'd0;
        err = 1'b0;
        rd  = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        busy_seen = 1'b0;
        cs_n = 1'b0;
        tick(6);
        check_eq("frame_start_busy", 32'(busy), 32'd1);
        check_eq("frame_start_hold", 32'(hold_n), 32'd0);
        check_eq("frame_start_err", 32'(error_flag), 32'd0);
        if (bytes.size() > 0) begin
            cmd = bytes[0];
            a   = cmd[6:0];
            rd  = cmd[7];
            err = int'(a) >= NumRegs;
        end
        for (int i = 0; i < bytes.size(); i++) begin
            last = coincident && (i == bytes.size() - 1);
            if (i > 0) begin
                if (rd) begin
                    check_eq("tx_before_byte", 32'(tx_data), 32'(model_tx(a)));
                end else if (int'(a) < NumRegs) begin
                    exp_a.push_back({1'b0, a});
                    exp_d.push_back(bytes[i]);
                end else begin
                    err = 1'b1;
                end
                a = model_inc(a);
            end
            send_byte(bytes[i], last);
        end
        if (rd) check_eq("tx_after_last", 32'(tx_data), 32'(model_tx(a)));
        if (!coincident) begin
            cs_n = 1'b1;
            tick(2);
            check_eq("hold_still_low", 32'(hold_n), 32'd0);
            tick(1);
            check_eq("hold_rise_1clk", 32'(hold_n), 32'd1);
        end
        tick(6);
        check_eq("frame_end_busy", 32'(busy), 32'd0);
        check_eq("frame_end_hold", 32'(hold_n), 32'd1);
        check_eq("busy_pulsed", 32'(busy_seen), 32'd1);
        check_eq("error_flag", 32'(error_flag), 32'(err));
        if (bytes.size() > 0) check_eq("final_addr", 32'(address_bus), {25'd0, a});
        check_eq("write_count", 32'(wr_addr_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wr_addr_q.size(); i++) begin
            check_eq("write_addr", 32'(wr_addr_q[i]), 32'(exp_a[i]));
            check_eq("write_data", 32'(wr_data_q[i]), 32'(exp_d[i]));
        end
    endtask

    initial begin
        logic [7:0] fr[$];
        int         nb;
        bit         coin;
        RST     = 1'b1;
        cs_n    = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tick(3);
        RST = 1'b0;
        check_eq("rst_write", 32'(write_n), 32'd1);
        check_eq("rst_hold", 32'(hold_n), 32'd1);
        check_eq("rst_addr", 32'(address_bus), 32'd0);
        check_eq("rst_wbus", 32'(write_bus), 32'd0);
        check_eq("rst_tx", 32'(tx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(error_flag), 32'd0);
        tick(5);

        fr = '{8'h01, 8'h40, 8'h80};        run_frame(fr, 1'b0);
        fr = '{8'h03, 8'hAA, 8'hBB};        run_frame(fr, 1'b0);
        fr = '{8'h82, 8'h00, 8'h00};        run_frame(fr, 1'b0);
        fr = '{8'h05, 8'h77};               run_frame(fr, 1'b0);
        fr = '{8'h7F, 8'h31, 8'h32};        run_frame(fr, 1'b0);
        fr = '{8'h02, 8'h11, 8'h22};        run_frame(fr, 1'b1);
        fr = {};                            run_frame(fr, 1'b0);

        // Strobe and increment latency relative to the asynchronous RXDone rise.
        wr_addr_q.delete();
        wr_data_q.delete();
        cs_n = 1'b0;
        tick(6);
        send_byte(8'h00, 1'b0);
        rx_data = 8'h5A;
        rx_done = 1'b1;
        tick(2);
        check_eq("lat_write_not_yet", 32'(write_n), 32'd1);
        tick(1);
        check_eq("lat_write_low", 32'(write_n), 32'd0);
        check_eq("lat_write_data", 32'(write_bus), 32'h5A);
        check_eq("lat_write_addr", 32'(address_bus), 32'd0);
        tick(1);
        check_eq("lat_write_high", 32'(write_n), 32'd1);
        check_eq("lat_addr_hold", 32'(address_bus), 32'd0);
        tick(1);
        check_eq("lat_addr_inc", 32'(address_bus), 32'd1);
        rx_done = 1'b0;
        tick(6);
        cs_n = 1'b1;
        tick(8);

        // Reset mid-frame: remaining bytes of the frame must be ignored.
        wr_addr_q.delete();
        wr_data_q.delete();
        cs_n = 1'b0;
        tick(6);
        send_byte(8'h01, 1'b0);
        rx_data = 8'h40;
        rx_done = 1'b1;
        RST     = 1'b1;
        tick(2);
        RST = 1'b0;
        check_eq("mid_rst_write", 32'(write_n), 32'd1);
        check_eq("mid_rst_hold", 32'(hold_n), 32'd1);
        check_eq("mid_rst_addr", 32'(address_bus), 32'd0);
        check_eq("mid_rst_wbus", 32'(write_bus), 32'd0);
        check_eq("mid_rst_tx", 32'(tx_data), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_err", 32'(error_flag), 32'd0);
        tick(2);
        rx_done = 1'b0;
        tick(6);
        send_byte(8'h55, 1'b0);
        check_eq("mid_rst_still_idle", 32'(busy), 32'd0);
        cs_n = 1'b1;
        tick(8);
        check_eq("mid_rst_no_writes", 32'(wr_addr_q.size()), 32'd0);

        for (int f = 0; f < 40; f++) begin
            fr = {};
            coin = 1'b0;
            nb   = $urandom_range(0, 4);
            if (nb > 0) begin
                fr.push_back({1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127))
                                                          : 7'($urandom_range(0, 6))});
                for (int j = 1; j < nb; j++) fr.push_back(8'($urandom));
                coin = !fr[0][7] && nb > 1 && ($urandom_range(0, 3) == 0);
            end
            run_frame(fr, coin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
